// File: rtl/inst_mem_fetch.sv
// Registered instruction memory with a request/valid fetch port (stall, flush) and a streaming program-load port.
// Optional IMEM_OOB_TRAP_EN adds oob_fault for out-of-range fetches and dropped load beats.
module inst_mem_fetch #(
  parameter int INST_W = 16,
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 256
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              fetch_req,
  input  logic [ADDR_W-1:0] fetch_pc,
  output logic              fetch_ready,
  output logic              inst_valid,
  output logic [INST_W-1:0] inst,
  output logic [ADDR_W-1:0] inst_pc,
  input  logic              inst_stall,
  input  logic              flush,
  input  logic              load_start,
  input  logic              load_valid,
  input  logic [INST_W-1:0] load_data,
  input  logic              load_last,
  output logic              load_err,
`ifdef IMEM_OOB_TRAP_EN
  output logic              oob_fault,
`endif
  output logic              dbg_state_o
);

  localparam int PTR_W = ADDR_W + 1;
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W-1:0] DEPTH_P = PTR_W'(DEPTH);

  typedef enum logic {READY = 1'b0, LOADING = 1'b1} state_t;

  // Handshake: a fetch is accepted on a rising edge where fetch_req && fetch_ready;
  // the word appears with inst_valid one cycle later and is held while inst_stall is high.

  state_t              state_q, state_d;
  logic [PTR_W-1:0]    ptr_q, ptr_d;
  logic                err_q, err_d;
  logic                valid_q, valid_d;
  logic [ADDR_W-1:0]   pc_q, pc_d;
  logic [INST_W-1:0]   inst_q;
  logic                wr_en;
  logic                accept;
  logic                in_range;
  logic [INST_W-1:0]   mem [DEPTH];

  assign in_range    = {1'b0, fetch_pc} < DEPTH_P;
  assign fetch_ready = (state_q == READY) && !load_start && !(valid_q && inst_stall);
  assign accept      = fetch_req && fetch_ready;

`ifdef IMEM_OOB_TRAP_EN
  logic oob_q, oob_d;
`endif

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    err_d   = err_q;
    valid_d = 1'b0;
    pc_d    = pc_q;
    wr_en   = 1'b0;
`ifdef IMEM_OOB_TRAP_EN
    oob_d   = 1'b0;
`endif
    case (state_q)
      READY: begin
        if (load_start) begin
          state_d = LOADING;
          ptr_d   = '0;
          err_d   = 1'b0;
        end else if (accept) begin
          // An accepted fetch also covers flush: the redirect target wins.
          valid_d = 1'b1;
          pc_d    = fetch_pc;
`ifdef IMEM_OOB_TRAP_EN
          oob_d   = !in_range;
`endif
        end else if (!flush && valid_q && inst_stall) begin
          valid_d = 1'b1;
`ifdef IMEM_OOB_TRAP_EN
          oob_d   = oob_q;
`endif
        end
      end
      LOADING: begin
        if (load_start) begin
          ptr_d = '0;
          err_d = 1'b0;
        end else if (load_valid) begin
          if (ptr_q < DEPTH_P) begin
            wr_en = 1'b1;
            ptr_d = ptr_q + 1'b1;
          end else begin
            err_d = 1'b1;
          end
          if (load_last) state_d = READY;
        end
      end
      default: state_d = READY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= READY;
      ptr_q   <= '0;
      err_q   <= 1'b0;
      valid_q <= 1'b0;
      pc_q    <= '0;
      inst_q  <= '0;
`ifdef IMEM_OOB_TRAP_EN
      oob_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      err_q   <= err_d;
      valid_q <= valid_d;
      pc_q    <= pc_d;
`ifdef IMEM_OOB_TRAP_EN
      oob_q   <= oob_d;
`endif
      if (accept) inst_q <= in_range ? mem[fetch_pc[IDX_W-1:0]] : '0;
    end
  end

  // Contents survive reset so a partial load is never rolled back.
  always_ff @(posedge clk) begin
    if (wr_en) mem[ptr_q[IDX_W-1:0]] <= load_data;
  end

  assign inst_valid  = valid_q;
  assign inst        = inst_q;
  assign inst_pc     = pc_q;
  assign load_err    = err_q;
  assign dbg_state_o = (state_q == LOADING);
`ifdef IMEM_OOB_TRAP_EN
  assign oob_fault   = oob_q | err_q;
`endif

endmodule

// File: tb/tb_inst_mem_fetch.sv
// Directed bench for inst_mem_fetch (DEPTH=4) covering load, fetch, stall, flush, overflow and reset-mid-load.
module tb_inst_mem_fetch;

  localparam int INST_W = 16;
  localparam int ADDR_W = 8;
  localparam int DEPTH  = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic              fetch_req;
  logic [ADDR_W-1:0] fetch_pc;
  logic              fetch_ready;
  logic              inst_valid;
  logic [INST_W-1:0] inst;
  logic [ADDR_W-1:0] inst_pc;
  logic              inst_stall;
  logic              flush;
  logic              load_start;
  logic              load_valid;
  logic [INST_W-1:0] load_data;
  logic              load_last;
  logic              load_err;
  logic              dbg_state;
`ifdef IMEM_OOB_TRAP_EN
  logic              oob_fault;
`endif

  int n_cmp = 0;
  int n_bad = 0;
  logic [INST_W-1:0] exp_q[$];

  inst_mem_fetch #(.INST_W(INST_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .fetch_req(fetch_req), .fetch_pc(fetch_pc), .fetch_ready(fetch_ready),
    .inst_valid(inst_valid), .inst(inst), .inst_pc(inst_pc),
    .inst_stall(inst_stall), .flush(flush),
    .load_start(load_start), .load_valid(load_valid), .load_data(load_data),
    .load_last(load_last), .load_err(load_err),
`ifdef IMEM_OOB_TRAP_EN
    .oob_fault(oob_fault),
`endif
    .dbg_state_o(dbg_state)
  );

  // Clock / reset
  always #5 clk = ~clk;

  // Checking
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Drivers: inputs change 1 time unit after the rising edge, outputs are sampled there too.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    fetch_req = 1'b0; fetch_pc = '0; inst_stall = 1'b0; flush = 1'b0;
    load_start = 1'b0; load_valid = 1'b0; load_data = '0; load_last = 1'b0;
  endtask

  task automatic start_load();
    load_start = 1'b1;
    step();
    load_start = 1'b0;
  endtask

  task automatic beat(input logic [INST_W-1:0] d, input logic last);
    load_valid = 1'b1; load_data = d; load_last = last;
    step();
    load_valid = 1'b0; load_last = 1'b0;
  endtask

  task automatic fetch(input logic [ADDR_W-1:0] pc);
    fetch_req = 1'b1; fetch_pc = pc;
    step();
    fetch_req = 1'b0;
  endtask

  task automatic expect_word(input string tag, input logic [ADDR_W-1:0] pc);
    logic [INST_W-1:0] e;
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 16'hDEAD;
    chk({tag, "_valid"}, 32'(inst_valid), 32'd1);
    chk({tag, "_inst"}, 32'(inst), 32'(e));
    chk({tag, "_pc"}, 32'(inst_pc), 32'(pc));
  endtask

  initial begin
    idle_inputs();
    reset = 1'b1;
    step(); step();
    chk("rst_valid", 32'(inst_valid), 32'd0);
    chk("rst_inst", 32'(inst), 32'd0);
    chk("rst_pc", 32'(inst_pc), 32'd0);
    chk("rst_err", 32'(load_err), 32'd0);
    chk("rst_state", 32'(dbg_state), 32'd0);
    chk("rst_ready", 32'(fetch_ready), 32'd1);
    reset = 1'b0;

    // 1: load four words, fetch them back-to-back
    load_start = 1'b1; #1;
    chk("t1_ready_on_start", 32'(fetch_ready), 32'd0);
    step();
    load_start = 1'b0;
    chk("t1_loading", 32'(dbg_state), 32'd1);
    beat(16'h1111, 1'b0); beat(16'h2222, 1'b0); beat(16'h3333, 1'b0);
    chk("t1_still_loading", 32'(dbg_state), 32'd1);
    beat(16'h4444, 1'b1);
    chk("t1_ready_after_last", 32'(fetch_ready), 32'd1);
    chk("t1_err", 32'(load_err), 32'd0);
    exp_q = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
    for (int i = 0; i < 4; i++) begin
      fetch_req = 1'b1; fetch_pc = 8'(i);
      step();
      expect_word("t1_word", 8'(i));
    end
    fetch_req = 1'b0;
    step();
    chk("t1_idle_valid", 32'(inst_valid), 32'd0);
    chk("t1_idle_inst_hold", 32'(inst), 32'h4444);

    // 2: stall holds the output for three cycles
    fetch(8'd2);
    chk("t2_inst", 32'(inst), 32'h3333);
    inst_stall = 1'b1; fetch_req = 1'b1; fetch_pc = 8'd3; #1;
    chk("t2_ready_stalled", 32'(fetch_ready), 32'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t2_hold_valid", 32'(inst_valid), 32'd1);
      chk("t2_hold_inst", 32'(inst), 32'h3333);
      chk("t2_hold_pc", 32'(inst_pc), 32'd2);
      chk("t2_hold_ready", 32'(fetch_ready), 32'd0);
    end
    inst_stall = 1'b0; #1;
    chk("t2_ready_release", 32'(fetch_ready), 32'd1);
    step();
    fetch_req = 1'b0;
    chk("t2_next_inst", 32'(inst), 32'h4444);
    chk("t2_next_pc", 32'(inst_pc), 32'd3);

    // 3: flush redirect wins over a held word; flush alone drops a stalled word
    fetch(8'd1);
    inst_stall = 1'b1;
    step();
    chk("t3_held_inst", 32'(inst), 32'h2222);
    inst_stall = 1'b0; flush = 1'b1; fetch_req = 1'b1; fetch_pc = 8'd0;
    step();
    flush = 1'b0; fetch_req = 1'b0;
    chk("t3_redir_valid", 32'(inst_valid), 32'd1);
    chk("t3_redir_inst", 32'(inst), 32'h1111);
    chk("t3_redir_pc", 32'(inst_pc), 32'd0);
    fetch(8'd3);
    inst_stall = 1'b1; flush = 1'b1;
    step();
    inst_stall = 1'b0; flush = 1'b0;
    chk("t3_flush_over_stall", 32'(inst_valid), 32'd0);

    // 4: overflow a DEPTH=4 memory with six beats
    start_load();
    for (int i = 0; i < 4; i++) beat(16'hA000 + 16'(i), 1'b0);
    chk("t4_err_before_drop", 32'(load_err), 32'd0);
    beat(16'hA004, 1'b0);
    chk("t4_err_after_drop", 32'(load_err), 32'd1);
    beat(16'hA005, 1'b1);
    chk("t4_err_sticky", 32'(load_err), 32'd1);
    chk("t4_ready", 32'(dbg_state), 32'd0);
`ifdef IMEM_OOB_TRAP_EN
    chk("t4_oob_from_load", 32'(oob_fault), 32'd1);
`endif
    exp_q = '{16'hA000, 16'hA001, 16'hA002, 16'hA003, 16'h0000, 16'h0000};
    for (int i = 0; i < 4; i++) begin
      fetch(8'(i));
      expect_word("t4_word", 8'(i));
    end
    fetch(8'd5);
    expect_word("t4_oob5", 8'd5);
    fetch(8'd255);
    expect_word("t4_oob255", 8'd255);

    // 5: load_start drops a valid word; fetches are refused while loading
    fetch(8'd0);
    chk("t5_valid_before", 32'(inst_valid), 32'd1);
    start_load();
    chk("t5_valid_dropped", 32'(inst_valid), 32'd0);
    chk("t5_err_cleared", 32'(load_err), 32'd0);
    beat(16'h1111, 1'b0);
    fetch_req = 1'b1; fetch_pc = 8'd1; #1;
    chk("t5_ready_loading", 32'(fetch_ready), 32'd0);
    step();
    fetch_req = 1'b0;
    chk("t5_no_accept", 32'(inst_valid), 32'd0);
    beat(16'h2222, 1'b0); beat(16'h3333, 1'b0);
    chk("t5_ready_pre_last", 32'(fetch_ready), 32'd0);
    beat(16'h4444, 1'b1);
    chk("t5_ready_post_last", 32'(fetch_ready), 32'd1);

    // 6: reset in the middle of a load keeps the partial image
    start_load();
    beat(16'h5555, 1'b0); beat(16'h6666, 1'b0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("t6_state", 32'(dbg_state), 32'd0);
    chk("t6_valid", 32'(inst_valid), 32'd0);
    exp_q = '{16'h5555, 16'h6666, 16'h3333, 16'h4444};
    for (int i = 0; i < 4; i++) begin
      fetch(8'(i));
      expect_word("t6_word", 8'(i));
    end

`ifdef IMEM_OOB_TRAP_EN
    fetch(8'd7);
    chk("t7_oob_set", 32'(oob_fault), 32'd1);
    chk("t7_oob_inst", 32'(inst), 32'd0);
    fetch(8'd0);
    chk("t7_oob_clear", 32'(oob_fault), 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end

endmodule

// File: doc/inst_mem_fetch.md
Name: inst_mem_fetch

Overview:
- Parametrised synchronous successor to the combinational instruction memory of the S-Machine CPU.
- Sits between the PC/fetch stage and decode. Provides a registered read of configurable word width and depth.
- Fetch uses a request/valid handshake with stall hold and flush.
- A streaming program-load port writes memory at run time, so simulation and bring-up do not depend on a file image.

Parameters:
- INST_W, 16, instruction word width in bits
- ADDR_W, 8, PC width; addressable space is 2^ADDR_W words
- DEPTH, 256, implemented words; must satisfy DEPTH <= 2^ADDR_W (need not be a power of two)

Ports:
- clk  in  1  system clock; all state changes on its rising edge
- reset  in  1  synchronous, active-high reset
- fetch_req  in  1  fetch request, qualified by fetch_ready
- fetch_pc  in  ADDR_W  word address to fetch
- fetch_ready  out  1  block can accept a fetch this cycle
- inst_valid  out  1  inst/inst_pc hold a valid fetched word
- inst  out  INST_W  fetched instruction
- inst_pc  out  ADDR_W  address that inst came from
- inst_stall  in  1  decode cannot consume; hold the output
- flush  in  1  discard any in-flight or held fetch result
- load_start  in  1  enter LOADING and clear the write pointer
- load_valid  in  1  load_data beat is present
- load_data  in  INST_W  word to write
- load_last  in  1  final beat of the load, qualified by load_valid
- load_err  out  1  sticky: a load beat was dropped because it exceeded DEPTH

Behaviour:
- Reset (synchronous, active-high):
  - state=READY, inst_valid=0, inst=0, inst_pc=0, load_err=0, write pointer=0.
  - Memory contents are not cleared.
- FSM states: READY and LOADING.
- READY to LOADING:
  - Occurs on load_start. The write pointer is set to 0 and load_err is cleared.
  - load_start while already LOADING restarts the load: pointer=0, load_err cleared.
- LOADING, per load_valid beat:
  - If pointer < DEPTH: write mem[pointer]=load_data, then pointer+1.
  - Otherwise: drop the beat and set load_err.
  - load_valid with load_last writes (or drops) that beat, then returns to READY next cycle.
  - load_valid=0 beats are ignored; there is no timeout.
- fetch_ready = (state==READY) && !load_start && !(inst_valid && inst_stall).
- Fetch accept occurs when fetch_req && fetch_ready.
- Fetch latency: 1 cycle. The cycle after accept gives inst_valid=1, inst=mem[fetch_pc], inst_pc=fetch_pc.
- Back-to-back accepts sustain one word per cycle.
- fetch_pc >= DEPTH returns inst=0 (treated as NOP) with inst_valid=1.
- Stall: while inst_valid && inst_stall, inst, inst_pc and inst_valid hold unchanged and fetch_ready=0.
- No fetch accepted in a cycle: inst_valid falls to 0 next cycle, unless held by stall.
- Flush:
  - flush forces inst_valid=0 next cycle, overriding stall hold.
  - flush together with an accepted fetch: the new fetch wins. Next cycle inst_valid=1 with the new address; this is the branch-redirect case.
  - flush does not affect LOADING.
- LOADING cycles:
  - fetch_ready=0.
  - Any held output is dropped (inst_valid=0) on entry to LOADING.
- Read during a write to the same address cannot occur, because fetch and load are mutually exclusive.
- Reset mid-load:
  - Returns to READY with pointer=0.
  - Words already written remain; the partial image is not rolled back.
- inst, inst_pc when inst_valid=0: hold their last value (don't-care for decode).

Optional Feature:
- Macro: IMEM_OOB_TRAP_EN.
- Defined:
  - Adds output port oob_fault (1 bit, reset 0).
  - It is asserted together with inst_valid for a fetch whose fetch_pc >= DEPTH. inst=0 as normal.
  - It clears when inst_valid drops or the next in-range word is presented.
  - It is also set, sticky until the next load_start or reset, when load_err sets.
- Not defined: port absent; out-of-range fetches silently return 0.

Test Plan:
1. Reset, load_start, then 4 beats 0x1111, 0x2222, 0x3333, 0x4444 with load_last on the 4th; fetch pc 0..3 back-to-back -> inst_valid on cycles 1..4 after the first accept, inst=0x1111..0x4444, inst_pc=0..3, load_err=0.
2. Fetch pc=2 accepted, then inst_stall=1 for 3 cycles with fetch_req=1 pc=3 -> inst=0x3333 and inst_pc=2 held 3 cycles, fetch_ready=0; stall drops -> pc=3 accepted, inst=0x4444 next cycle.
3. Held stalled output pc=1, then flush=1 plus fetch_req pc=0 in the same cycle -> next cycle inst_valid=1, inst=0x1111, inst_pc=0 (redirect wins over hold).
4. DEPTH=4, load 6 beats -> mem[0..3] written, beats 5 and 6 dropped, load_err=1; fetch pc=5 -> inst=0, inst_valid=1; with IMEM_OOB_TRAP_EN, oob_fault=1 for that word.
5. load_start while inst_valid=1 -> inst_valid=0 next cycle, fetch_ready=0 through LOADING; load_last beat -> fetch_ready=1 the following cycle.
6. Reset asserted after 2 of 4 load beats -> state READY, pointer 0; mem[0..1] hold the new words and mem[2..3] the old ones on readback.
